// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver.
// Glyph table is bit7=a .. bit1=g, bit0=dp, active-high.
package seg_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] BLANK_GLYPH = 8'h00;

  localparam logic [15:0][7:0] GLYPH_TAB = {
    8'h8e, 8'h9e, 8'h7a, 8'h9c,
    8'h3e, 8'hee, 8'hf6, 8'hfe,
    8'he0, 8'hbe, 8'hb6, 8'h66,
    8'hf2, 8'hda, 8'h60, 8'hfc
  };

endpackage

// File: rtl/seg_scan_driver_hex.sv
// Combinational hex nibble plus decimal point to segment glyph.
// Used once, after the digit mux.
import seg_pkg::*;

module hex_to_seg (
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] glyph
);

  // table lookup, dp lands on its own bit
  always_comb begin
    glyph         = GLYPH_TAB[nib];
    glyph[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with frame-synchronous load.
// Define SEG_LZ_BLANK_EN to auto-blank leading zero digits.
import seg_pkg::*;

module seg_scan_driver #(
  parameter int N_DIGITS = 8,
  parameter int GROUP    = 4,
  parameter int DIV_MAX  = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  load,
  output logic                  load_ack,
  output logic                  frame_tick,
  output logic [7:0]            seg0,
  output logic [7:0]            seg1,
  output logic [N_DIGITS-1:0]   an
);

  localparam int IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int IW1 = IW + 1;
  localparam int DW  = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

  localparam logic [DW-1:0]  DIV_TOP  = DW'(DIV_MAX);
  localparam logic [IW-1:0]  IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [IW1-1:0] GRP      = IW1'(GROUP);

  logic [DW-1:0]           div;
  logic [IW-1:0]           idx;
  logic                    tick;
  logic                    wrap;

  logic [4*N_DIGITS-1:0]   pend_data;
  logic [N_DIGITS-1:0]     pend_dp;
  logic [N_DIGITS-1:0]     pend_blank;
  logic                    pend_vld;

  logic [4*N_DIGITS-1:0]   act_data;
  logic [N_DIGITS-1:0]     act_dp;
  logic [N_DIGITS-1:0]     act_blank;

  logic                    wrap_q;
  logic                    ack_q;

  logic [N_DIGITS-1:0]     lz_blank;
  logic [N_DIGITS-1:0]     an_nxt;
  logic [3:0]              nib;
  logic                    dp_sel;
  logic                    blank_sel;
  logic [7:0]              glyph;
  logic [7:0]              glyph_out;
  logic                    in_grp1;

  assign tick = (div == DIV_TOP);
  assign wrap = tick && (idx == IDX_LAST);

  // dwell divider: count up to DIV_MAX then restart
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // scan index advances per tick and wraps at the last digit
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (wrap) begin
      idx <= '0;
    end else if (tick) begin
      idx <= idx + 1'b1;
    end
  end

  // double-buffered display data; commit only at the frame wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_vld   <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else begin
      if (wrap && pend_vld) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      if (load) begin
        pend_data  <= data_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_vld   <= 1'b1;
      end else if (wrap) begin
        pend_vld   <= 1'b0;
      end
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic lz_acc;

  // dark every digit above the top nonzero nibble or dp
  always_comb begin
    lz_acc   = 1'b0;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lz_acc      = lz_acc | (|act_data[4*i +: 4]) | act_dp[i];
      lz_blank[i] = ~lz_acc;
    end
    lz_blank[0] = 1'b0;
  end
`else
  assign lz_blank = '0;
`endif

  // select the scanned digit ahead of the output registers
  always_comb begin
    an_nxt      = '0;
    an_nxt[idx] = 1'b1;
    nib         = act_data[{idx, 2'b00} +: 4];
    dp_sel      = act_dp[idx];
    blank_sel   = act_blank[idx] | lz_blank[idx];
    in_grp1     = ({1'b0, idx} < GRP);
  end

  hex_to_seg u_hex (
    .nib   (nib),
    .dp    (dp_sel),
    .glyph (glyph)
  );

  assign glyph_out = blank_sel ? BLANK_GLYPH : glyph;

  // frame and ack pulses lag the commit to align with digit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q     <= 1'b0;
      ack_q      <= 1'b0;
      frame_tick <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      wrap_q     <= wrap;
      ack_q      <= wrap && pend_vld;
      frame_tick <= wrap_q;
      load_ack   <= ack_q;
    end
  end

  // registered digit select and segment buses
  always_ff @(posedge clk) begin
    if (rst) begin
      an   <= N_DIGITS'(1);
      seg0 <= BLANK_GLYPH;
      seg1 <= BLANK_GLYPH;
    end else begin
      an <= an_nxt;
      if (in_grp1) begin
        seg1 <= glyph_out;
        seg0 <= BLANK_GLYPH;
      end else begin
        seg0 <= glyph_out;
        seg1 <= BLANK_GLYPH;
      end
    end
  end

endmodule
